// File: rtl/pdm_cic_decimator.sv
// PDM microphone front end: generates the microphone clock, synchronizes the
// 1-bit PDM stream, and decimates it with a 4-stage CIC (N=4, M=1, R=2^DECIM_LOG2)
// into signed Q15 samples. Each output sample comes with a single-cycle valid pulse.
module pdm_cic_decimator #(
  parameter int CLK_DIV    = 4,
  parameter int DECIM_LOG2 = 6
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               pdm_data_in,
  output logic               pdm_clk_out,
  output logic signed [15:0] sample_out,
  output logic               sample_valid
);

  localparam int ACC_W    = 4*DECIM_LOG2 + 2;
  localparam int SHIFT    = 4*DECIM_LOG2 - 15;
  localparam int DIV_W    = $clog2(CLK_DIV);
  localparam int N_STAGES = 4;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [2:0]       WARMUP   = 3'd4;

  typedef logic signed [ACC_W-1:0] acc_t;

  localparam acc_t SAT_HI = acc_t'(32767);
  localparam acc_t SAT_LO = acc_t'(-32768);

  // Clock generation
  logic [DIV_W-1:0] r_div_cnt;
  logic             r_pdm_clk;
  logic             w_pdm_tick;

  // Input synchronizer; r_sync[1] is the bit that is safe to use
  logic [1:0] r_sync;
  acc_t       w_x;

  // Integrator cascade
  acc_t r_integ      [N_STAGES];
  acc_t w_integ_next [N_STAGES];

  // Decimation
  logic [DECIM_LOG2-1:0] r_dec_cnt;
  logic                  w_capture;

  // Comb pipeline
  acc_t r_comb      [N_STAGES];
  acc_t r_dly       [N_STAGES];
  logic r_comb_vld  [N_STAGES];
  acc_t w_stage_in  [N_STAGES];
  logic w_stage_vld [N_STAGES];

  // Scale and warm-up
  acc_t              w_shifted;
  logic signed [15:0] w_sat;
  logic [2:0]        r_warm_cnt;

  // Half-period counter; pdm clock toggles on the cycle after each wrap
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: every clocked register uses non-blocking assignment so that all
    // flops sample the pre-edge values and simulation order cannot matter.
    if (!reset_n) begin
      r_div_cnt <= '0;
      r_pdm_clk <= 1'b0;
    end else if (r_div_cnt == DIV_LAST) begin
      r_div_cnt <= '0;
      r_pdm_clk <= ~r_pdm_clk;
    end else begin
      r_div_cnt <= r_div_cnt + DIV_W'(1);
    end
  end

  // Sample strobe in the last clk of each high phase, just before the falling edge
  assign w_pdm_tick  = r_pdm_clk && (r_div_cnt == DIV_LAST);
  assign pdm_clk_out = r_pdm_clk;

  // Two-flop synchronizer for the asynchronous microphone data
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_sync <= '0;
    else          r_sync <= {r_sync[0], pdm_data_in};
  end

  // Map the synchronized bit to +1 / -1
  assign w_x = r_sync[1] ? acc_t'(1) : acc_t'(-1);

  // Integrator cascade: each stage adds the freshly updated upstream value
  always_comb begin
    acc_t v_sum;
    v_sum = w_x;
    for (int k = 0; k < N_STAGES; k++) begin
      v_sum           = r_integ[k] + v_sum;
      w_integ_next[k] = v_sum;
    end
  end

  // Integrators advance only on pdm ticks; wrap-around is intended
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: these arrays are real state with a defined start-up value, so they
    // are cleared in reset; a storage RAM would not need (or allow) this.
    if (!reset_n) begin
      for (int k = 0; k < N_STAGES; k++) r_integ[k] <= '0;
    end else if (w_pdm_tick) begin
      for (int k = 0; k < N_STAGES; k++) r_integ[k] <= w_integ_next[k];
    end
  end

  // Decimation counter; the R-th tick hands I4 to the comb pipeline
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)        r_dec_cnt <= '0;
    else if (w_pdm_tick) r_dec_cnt <= r_dec_cnt + DECIM_LOG2'(1);
  end

  assign w_capture = w_pdm_tick && (&r_dec_cnt);

  // Comb stage inputs: stage 0 takes the post-update I4, later stages chain
  always_comb begin
    w_stage_in[0]  = w_integ_next[N_STAGES-1];
    w_stage_vld[0] = w_capture;
    for (int k = 1; k < N_STAGES; k++) begin
      w_stage_in[k]  = r_comb[k-1];
      w_stage_vld[k] = r_comb_vld[k-1];
    end
  end

  // Comb stages: difference against the previous decimated input, one clk each
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < N_STAGES; k++) begin
        r_comb[k]     <= '0;
        r_dly[k]      <= '0;
        r_comb_vld[k] <= 1'b0;
      end
    end else begin
      for (int k = 0; k < N_STAGES; k++) begin
        r_comb_vld[k] <= w_stage_vld[k];
        if (w_stage_vld[k]) begin
          r_comb[k] <= w_stage_in[k] - r_dly[k];
          r_dly[k]  <= w_stage_in[k];
        end
      end
    end
  end

  // Scale the full-gain CIC result down to Q15 with saturation
  assign w_shifted = r_comb[N_STAGES-1] >>> SHIFT;

  // Clamp to the 16-bit range; +full scale lands one LSB above 32767
  always_comb begin
    // NOTE: the default assignment first guarantees every path drives w_sat,
    // so no latch is inferred.
    w_sat = w_shifted[15:0];
    if (w_shifted > SAT_HI)      w_sat = 16'sh7FFF;
    else if (w_shifted < SAT_LO) w_sat = 16'sh8000;
  end

  // Output register; the first four results only advance the warm-up count
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_warm_cnt   <= '0;
      sample_valid <= 1'b0;
      sample_out   <= '0;
    end else begin
      sample_valid <= 1'b0;
      if (r_comb_vld[N_STAGES-1]) begin
        if (r_warm_cnt != WARMUP) begin
          r_warm_cnt <= r_warm_cnt + 3'd1;
        end else begin
          sample_valid <= 1'b1;
          sample_out   <= w_sat;
        end
      end
    end
  end

endmodule

// File: tb/tb_pdm_cic_decimator.sv
// Bench for pdm_cic_decimator. The stimulus drives one PDM bit per microphone
// clock (changed after each falling edge, as a real microphone does) and
// predicts each output from the CIC impulse response applied to the bit history.
// An independent monitor compares every valid pulse against the predictions.
module tb_pdm_cic_decimator;

  localparam int CLK_DIV    = 4;
  localparam int DECIM_LOG2 = 6;
  localparam int R          = 1 << DECIM_LOG2;
  localparam int PDM_PER    = 2 * CLK_DIV;
  localparam int OUT_PER    = PDM_PER * R;
  localparam int LATENCY    = 5;
  localparam int WARMUP     = 4;
  localparam int SHIFT      = 4*DECIM_LOG2 - 15;
  localparam int HLEN       = 4*R - 3;

  logic               clk = 1'b0;
  logic               reset_n;
  logic               pdm_data_in;
  logic               pdm_clk_out;
  logic signed [15:0] sample_out;
  logic               sample_valid;

  pdm_cic_decimator #(.CLK_DIV(CLK_DIV), .DECIM_LOG2(DECIM_LOG2)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .pdm_data_in  (pdm_data_in),
    .pdm_clk_out  (pdm_clk_out),
    .sample_out   (sample_out),
    .sample_valid (sample_valid)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  typedef enum {PAT_ONE, PAT_ZERO, PAT_3Q, PAT_HALF, PAT_RAND} pat_e;

  typedef struct {
    longint value;
    longint edge_no;
  } exp_t;

  exp_t   sb_q[$];
  int     xs[$];       // +1/-1 per PDM tick since the last reset
  longint h[HLEN];     // CIC impulse response: four cascaded length-R boxcars

  // Clk edges since reset release; tick k falls in the cycle after edge (k+1)*PDM_PER-1
  longint edge_cnt;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) edge_cnt <= 0;
    else          edge_cnt <= edge_cnt + 1;
  end

  // Expected output of decimation m (1-based): FIR over the bit history, then scale
  function automatic longint model_out(input int m);
    longint acc;
    int     last;
    acc  = 0;
    last = m*R - 1;
    for (int j = 0; j < HLEN; j++)
      if (last - j >= 0) acc += h[j] * longint'(xs[last - j]);
    acc = acc >>> SHIFT;
    if (acc > 32767)       acc = 32767;
    else if (acc < -32768) acc = -32768;
    return acc;
  endfunction

  function automatic logic pat_bit(input pat_e p, input int i, input int thr);
    case (p)
      PAT_ONE:  return 1'b1;
      PAT_ZERO: return 1'b0;
      PAT_3Q:   return (i % 4) != 3;
      PAT_HALF: return (i % 2) == 0;
      default:  return $urandom_range(0, 15) < thr;
    endcase
  endfunction

  // Wait (bounded) for the next falling edge of the microphone clock
  task automatic wait_pdm_fall();
    logic prev;
    bit   seen;
    prev = pdm_clk_out;
    seen = 1'b0;
    for (int c = 0; c < 2*PDM_PER && !seen; c++) begin
      @(negedge clk);
      if (prev && !pdm_clk_out) seen = 1'b1;
      prev = pdm_clk_out;
    end
    check("pdm_clk_fall_seen", seen, 1);
  endtask

  // Drive n_dec decimations worth of bits and queue the predicted outputs
  task automatic run_seg(input pat_e p, input int n_dec, input int thr);
    logic b;
    int   m;
    exp_t e;
    for (int i = 0; i < n_dec*R; i++) begin
      b = pat_bit(p, i, thr);
      pdm_data_in = b;
      xs.push_back(b ? 1 : -1);
      if (xs.size() % R == 0) begin
        m = xs.size() / R;
        if (m > WARMUP) begin
          e.value   = model_out(m);
          e.edge_no = longint'(m)*OUT_PER - 1 + LATENCY;
          sb_q.push_back(e);
        end
      end
      wait_pdm_fall();
    end
  endtask

  task automatic do_reset(input int hold_cycles);
    @(negedge clk);
    #1;
    reset_n = 1'b0;
    sb_q.delete();
    xs.delete();
    repeat (hold_cycles) @(posedge clk);
    @(negedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  // Monitor: reset values, hold behaviour, and every valid pulse vs the scoreboard
  initial begin
    logic   prev_valid;
    longint hold;
    exp_t   e;
    prev_valid = 1'b0;
    hold       = 0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        check("rst_sample_out", sample_out, 0);
        check("rst_sample_valid", sample_valid, 0);
        check("rst_pdm_clk_out", pdm_clk_out, 0);
        hold       = 0;
        prev_valid = 1'b0;
      end else begin
        if (sample_valid) begin
          check("valid_not_back_to_back", prev_valid, 0);
          check("valid_expected", sb_q.size() > 0, 1);
          if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check("sample_out", sample_out, e.value);
            check("valid_edge", edge_cnt, e.edge_no);
            hold = e.value;
          end
        end else begin
          check("sample_hold", sample_out, hold);
        end
        prev_valid = sample_valid;
      end
    end
  end

  // Clock monitor: high CLK_DIV / low CLK_DIV, tick on the last high clk
  initial begin
    forever begin
      @(negedge clk);
      if (reset_n) begin
        check("pdm_clk_out", pdm_clk_out, (edge_cnt / CLK_DIV) % 2);
        check("pdm_tick", dut.w_pdm_tick, (edge_cnt % PDM_PER) == PDM_PER - 1);
      end
    end
  end

  initial begin
    longint tmp[HLEN];

    for (int j = 0; j < HLEN; j++) h[j] = (j < R) ? 1 : 0;
    for (int s = 1; s < 4; s++) begin
      for (int j = 0; j < HLEN; j++) begin
        tmp[j] = 0;
        for (int i = 0; i < R && i <= j; i++) tmp[j] += h[j - i];
      end
      h = tmp;
    end

    pdm_data_in = 1'b0;
    reset_n     = 1'b1;
    #2;
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    reset_n = 1'b1;

    run_seg(PAT_ONE,  8, 0);
    run_seg(PAT_ZERO, 6, 0);
    run_seg(PAT_3Q,   6, 0);
    run_seg(PAT_HALF, 6, 0);
    run_seg(PAT_RAND, 4, 12);
    run_seg(PAT_RAND, 4, int'($urandom_range(0, 16)));

    // The last capture is now in the comb pipeline; reset drops it
    do_reset(3);
    run_seg(PAT_3Q, 7, 0);

    for (int c = 0; c < 64 && sb_q.size() > 0; c++) @(negedge clk);
    check("scoreboard_drained", sb_q.size(), 0);
    repeat (20) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
